// File: rtl/writeback_regfile.sv
// Writeback stage and 64-entry architectural register file.
// Selects the writeback value, commits it, and serves two bypassed read ports to decode.
module writeback_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              regWrite,
    input  logic              WAI,
    input  logic              memRead,
    input  logic [DATA_W-1:0] PC,
    input  logic [DATA_W-1:0] readData,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [ADDR_W-1:0] rd,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic [DATA_W-1:0] rsData,
    output logic [DATA_W-1:0] rtData,
    output logic [DATA_W-1:0] wbData,
    output logic              wbValid,
    output logic [ADDR_W-1:0] wbRd,
    output logic [CNT_W-1:0]  wbCount
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              commit;

    // Memory data outranks the PC link value, which outranks the ALU result.
    always_comb begin
        wbData = ALUResult;
        if (memRead) begin
            wbData = readData;
        end else if (WAI) begin
            wbData = PC;
        end
    end

    // A write presented during reset is dropped, so it must not bypass either.
    assign commit = regWrite && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[rd] <= wbData;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wbValid <= 1'b0;
            wbRd    <= '0;
            wbCount <= '0;
        end else if (commit) begin
            wbValid <= 1'b1;
            wbRd    <= rd;
            wbCount <= wbCount + 1'b1;
        end else begin
            wbValid <= 1'b0;
        end
    end

    always_comb begin
        rsData = regs[rs];
        rtData = regs[rt];
        if (commit && (rs == rd)) begin
            rsData = wbData;
        end
        if (commit && (rt == rd)) begin
            rtData = wbData;
        end
    end

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed self-checking bench for writeback_regfile.
module tb_writeback_regfile;

    logic        clock;
    logic        reset;
    logic        regWrite;
    logic        WAI;
    logic        memRead;
    logic [31:0] PC;
    logic [31:0] readData;
    logic [31:0] ALUResult;
    logic [5:0]  rd;
    logic [5:0]  rs;
    logic [5:0]  rt;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [31:0] wbData;
    logic        wbValid;
    logic [5:0]  wbRd;
    logic [31:0] wbCount;

    int checks   = 0;
    int failures = 0;

    writeback_regfile #(.DATA_W(32), .ADDR_W(6), .CNT_W(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .regWrite  (regWrite),
        .WAI       (WAI),
        .memRead   (memRead),
        .PC        (PC),
        .readData  (readData),
        .ALUResult (ALUResult),
        .rd        (rd),
        .rs        (rs),
        .rt        (rt),
        .rsData    (rsData),
        .rtData    (rtData),
        .wbData    (wbData),
        .wbValid   (wbValid),
        .wbRd      (wbRd),
        .wbCount   (wbCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, well away from it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic read_reg(input logic [5:0] idx, input logic [31:0] exp, input string tag);
        regWrite = 1'b0;
        rs = idx;
        rt = idx;
        #1;
        check({tag, "_rs"}, rsData, exp);
        check({tag, "_rt"}, rtData, exp);
    endtask

    initial begin
        reset = 1'b1; regWrite = 1'b0; WAI = 1'b0; memRead = 1'b0;
        PC = '0; readData = '0; ALUResult = '0; rd = '0; rs = '0; rt = '0;

        // Reset held for two edges, then sweep every entry.
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_count", wbCount, 32'd0);
        check("rst_valid", {31'd0, wbValid}, 32'd0);
        check("rst_rd", {26'd0, wbRd}, 32'd0);
        for (int i = 0; i < 64; i++) begin
            rs = 6'(i);
            rt = 6'(63 - i);
            #1;
            check("rst_sweep_rs", rsData, 32'd0);
            check("rst_sweep_rt", rtData, 32'd0);
        end

        // Writeback select priority on r5.
        ALUResult = 32'h11; readData = 32'h22; PC = 32'h33; rd = 6'd5;
        regWrite = 1'b1; memRead = 1'b0; WAI = 1'b0;
        #1;
        check("sel_alu_wbdata", wbData, 32'h11);
        tick();
        check("sel_alu_valid", {31'd0, wbValid}, 32'd1);
        check("sel_alu_rd", {26'd0, wbRd}, 32'd5);
        read_reg(6'd5, 32'h11, "sel_alu_r5");

        regWrite = 1'b1; memRead = 1'b0; WAI = 1'b1;
        #1;
        check("sel_pc_wbdata", wbData, 32'h33);
        tick();
        read_reg(6'd5, 32'h33, "sel_pc_r5");

        regWrite = 1'b1; memRead = 1'b1; WAI = 1'b1;
        #1;
        check("sel_mem_wbdata", wbData, 32'h22);
        tick();
        read_reg(6'd5, 32'h22, "sel_mem_r5");
        check("sel_count", wbCount, 32'd3);
        memRead = 1'b0; WAI = 1'b0;

        // Same-cycle bypass on both ports, then one port only.
        regWrite = 1'b1; rd = 6'd9; ALUResult = 32'hDEADBEEF; rs = 6'd9; rt = 6'd9;
        #1;
        check("byp_rs_pre", rsData, 32'hDEADBEEF);
        check("byp_rt_pre", rtData, 32'hDEADBEEF);
        rt = 6'd8;
        #1;
        check("byp_rt_other", rtData, 32'd0);
        rt = 6'd9;
        tick();
        regWrite = 1'b0;
        #1;
        check("byp_rs_post", rsData, 32'hDEADBEEF);
        check("byp_rt_post", rtData, 32'hDEADBEEF);
        check("byp_count", wbCount, 32'd4);

        // No-write cycle.
        regWrite = 1'b0; rd = 6'd7; ALUResult = 32'hFF; rs = 6'd7;
        #1;
        check("nowr_rs_pre", rsData, 32'd0);
        tick();
        check("nowr_valid", {31'd0, wbValid}, 32'd0);
        check("nowr_count", wbCount, 32'd4);
        check("nowr_rd_hold", {26'd0, wbRd}, 32'd9);
        read_reg(6'd7, 32'd0, "nowr_r7");

        // Reset beats a simultaneous commit; bypass is suppressed during reset.
        reset = 1'b1; regWrite = 1'b1; rd = 6'd3; ALUResult = 32'hAA; rs = 6'd3; rt = 6'd9;
        #1;
        check("rstp_nobypass", rsData, 32'd0);
        check("rstp_stored", rtData, 32'hDEADBEEF);
        tick();
        reset = 1'b0; regWrite = 1'b0;
        #1;
        check("rstp_count", wbCount, 32'd0);
        check("rstp_valid", {31'd0, wbValid}, 32'd0);
        read_reg(6'd3, 32'd0, "rstp_r3");
        read_reg(6'd9, 32'd0, "rstp_r9_cleared");
        regWrite = 1'b1; rd = 6'd3; ALUResult = 32'hAA; rs = 6'd3;
        #1;
        check("rstp_bypass_after", rsData, 32'hAA);
        tick();
        check("rstp_count_after", wbCount, 32'd1);
        read_reg(6'd3, 32'hAA, "rstp_r3_after");

        // Back-to-back commits to r0..r9 from a fresh reset.
        reset = 1'b1; regWrite = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            regWrite = 1'b1; rd = 6'(i); ALUResult = 32'h100 + 32'(i);
            tick();
        end
        regWrite = 1'b0;
        #1;
        check("cnt_count", wbCount, 32'd10);
        check("cnt_rd", {26'd0, wbRd}, 32'd9);
        check("cnt_valid", {31'd0, wbValid}, 32'd1);
        read_reg(6'd0, 32'h100, "cnt_r0");
        read_reg(6'd4, 32'h104, "cnt_r4");
        read_reg(6'd9, 32'h109, "cnt_r9");
        tick();
        check("cnt_idle_valid", {31'd0, wbValid}, 32'd0);
        check("cnt_idle_count", wbCount, 32'd10);
        check("cnt_idle_rd", {26'd0, wbRd}, 32'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
